// File: rtl/nor4_resp_checker.sv
// Response checker for a NOR stimulus flow: waits for each stimulus to settle, compares the DUT output to ~|stim, tallies results.
// Optional build macro CHK_STOP_ON_FAIL_EN: the first failing compare ends the run immediately.
module nor4_resp_checker #(
   parameter int WIDTH      = 4,
   parameter int SETTLE     = 2,
   parameter int NUM_CHECKS = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] stim,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_flag,
   output logic [WIDTH-1:0] last_fail_stim
);

   localparam int STAB_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam int CHK_W  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS + 1) : 1;
   localparam logic [STAB_W-1:0] SETTLE_V   = STAB_W'(SETTLE);
   localparam logic [CHK_W-1:0]  CHK_LAST_V = CHK_W'(NUM_CHECKS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MONITOR = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  stim_q, stim_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              checked_q, checked_d;
   logic [CHK_W-1:0]  chk_q, chk_d;
   logic [CNT_W-1:0]  pass_q, pass_d;
   logic [CNT_W-1:0]  fail_q, fail_d;
   logic              err_q, err_d;
   logic [WIDTH-1:0]  lf_q, lf_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic stim_chg;
   logic fire;
   logic match;

   always_comb begin
      state_d   = state_q;
      stim_d    = stim;
      stab_d    = stab_q;
      checked_d = checked_q;
      chk_d     = chk_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      err_d     = err_q;
      lf_d      = lf_q;

      stim_chg = (stim != stim_q);
      fire     = (state_q == MONITOR) && (stab_q == SETTLE_V) && !checked_q;
      match    = (dut_out == ~|stim_q);

      if (stim_chg) begin
         stab_d    = '0;
         checked_d = 1'b0;
      end else if (stab_q != SETTLE_V) begin
         stab_d = stab_q + STAB_W'(1);
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = MONITOR;
               checked_d = 1'b0;
               chk_d     = '0;
               pass_d    = '0;
               fail_d    = '0;
               err_d     = 1'b0;
               lf_d      = '0;
            end
         end
         MONITOR: begin
            if (fire) begin
               // a vector that changes on the compare edge is a new vector and stays unchecked
               if (!stim_chg) checked_d = 1'b1;
               chk_d = chk_q + CHK_W'(1);
               if (match) begin
                  if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
               end else begin
                  if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                  err_d = 1'b1;
                  lf_d  = stim_q;
               end
               if (chk_q == CHK_LAST_V) state_d = DONE;
`ifdef CHK_STOP_ON_FAIL_EN
               if (!match) state_d = DONE;
`else
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == MONITOR);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         stim_q    <= '0;
         stab_q    <= '0;
         checked_q <= 1'b0;
         chk_q     <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         err_q     <= 1'b0;
         lf_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         stim_q    <= stim_d;
         stab_q    <= stab_d;
         checked_q <= checked_d;
         chk_q     <= chk_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         err_q     <= err_d;
         lf_q      <= lf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign err_flag       = err_q;
   assign last_fail_stim = lf_q;

endmodule
